// File: rtl/mem_stage_ws_pkg.sv
// Shared constants for the memory stage.
// Opcode values, CPU exec state and MEM FSM encoding.
package mem_stage_ws_pkg;

    localparam logic       STATE_EXEC = 1'b1;
    localparam logic [4:0] OP_LOAD    = 5'b10010;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_t;

endpackage

// File: rtl/mem_stage_ws_req_latch.sv
// Request holding registers for a stalled memory access.
// Captures address, data, instruction and kind on load.
module mem_req_latch #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int IRW = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [AW-1:0]  addr,
    input  logic [DW-1:0]  data,
    input  logic [IRW-1:0] ir,
    input  logic           is_load,
    input  logic           is_store,
    output logic [AW-1:0]  req_addr,
    output logic [DW-1:0]  req_data,
    output logic [IRW-1:0] req_ir,
    output logic           req_load,
    output logic           req_store
);

    // Hold the request stable for the whole wait period
    always_ff @(posedge clock) begin
        if (!reset) begin
            req_addr  <= '0;
            req_data  <= '0;
            req_ir    <= '0;
            req_load  <= 1'b0;
            req_store <= 1'b0;
        end else if (load) begin
            req_addr  <= addr;
            req_data  <= data;
            req_ir    <= ir;
            req_load  <= is_load;
            req_store <= is_store;
        end
    end

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage with wait-state memory handshake.
// Stalls upstream while memory is slow; flags timeouts.
module mem_stage_ws
    import mem_stage_ws_pkg::*;
#(
    parameter int DW  = 16,
    parameter int AW  = 16,
    parameter int IRW = 16,
    parameter int OPW = 5,
    parameter int TMO = 15
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           state,
    input  logic [IRW-1:0] mem_ir,
    input  logic [DW-1:0]  reg_C,
    input  logic [DW-1:0]  smdr1,
    input  logic           dw,
    input  logic [DW-1:0]  d_datain,
    input  logic           d_ready,
    output logic [IRW-1:0] wb_ir,
    output logic [DW-1:0]  reg_C1,
    output logic [AW-1:0]  d_addr,
    output logic [DW-1:0]  d_dataout,
    output logic           d_we,
    output logic           d_re,
    output logic           stall,
    output logic           mem_err
);

    ms_state_t      fsm;
    logic [7:0]     wait_cnt;
    logic [OPW-1:0] op;
    logic           is_load;
    logic           is_store;
    logic           memop;
    logic           go;
    logic           start;
    logic           waiting;
    logic           timeout;
    logic           latch_en;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_data;
    logic [IRW-1:0] req_ir;
    logic           req_load;
    logic           req_store;

    assign op       = mem_ir[IRW-1 -: OPW];
    assign is_load  = (op == OPW'(OP_LOAD));
    assign is_store = dw & ~is_load;
    assign memop    = is_load | dw;
    assign go       = (fsm == MS_IDLE) && (state == STATE_EXEC);
    assign start    = go & memop;
    assign waiting  = (fsm == MS_WAIT);
    assign timeout  = waiting & ~d_ready & (wait_cnt == 8'(TMO));
    assign latch_en = start & ~d_ready;
    assign stall    = latch_en | (waiting & ~d_ready & ~timeout);

    mem_req_latch #(
        .AW  (AW),
        .DW  (DW),
        .IRW (IRW)
    ) u_req (
        .clock     (clock),
        .reset     (reset),
        .load      (latch_en),
        .addr      (reg_C[AW-1:0]),
        .data      (smdr1),
        .ir        (mem_ir),
        .is_load   (is_load),
        .is_store  (is_store),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ir    (req_ir),
        .req_load  (req_load),
        .req_store (req_store)
    );

    // Memory port: live request in IDLE, held request in WAIT
    always_comb begin
        d_addr    = reg_C[AW-1:0];
        d_dataout = smdr1;
        d_re      = start & is_load;
        d_we      = start & is_store;
        if (waiting) begin
            d_addr    = req_addr;
            d_dataout = req_data;
            d_re      = req_load;
            d_we      = req_store;
        end
        if (!reset) begin
            d_re = 1'b0;
            d_we = 1'b0;
        end
    end

    // Access FSM, wait counter and WB-side result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm      <= MS_IDLE;
            wait_cnt <= '0;
            wb_ir    <= '0;
            reg_C1   <= '0;
            mem_err  <= 1'b0;
        end else begin
            unique case (fsm)
                MS_IDLE: begin
                    if (go) begin
                        if (!memop) begin
                            wb_ir  <= mem_ir;
                            reg_C1 <= reg_C;
                        end else if (d_ready) begin
                            wb_ir  <= mem_ir;
                            reg_C1 <= is_load ? d_datain
                                              : DW'(reg_C[AW-1:0]);
                        end else begin
                            fsm      <= MS_WAIT;
                            wait_cnt <= 8'd1;
                            wb_ir    <= '0;
                        end
                    end
                end
                MS_WAIT: begin
                    if (d_ready) begin
                        fsm      <= MS_IDLE;
                        wait_cnt <= '0;
                        wb_ir    <= req_ir;
                        reg_C1   <= req_load ? d_datain
                                             : DW'(req_addr);
                    end else if (timeout) begin
                        fsm      <= MS_IDLE;
                        wait_cnt <= '0;
                        wb_ir    <= req_ir;
                        reg_C1   <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        wb_ir    <= '0;
                    end
                end
                default: fsm <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Self-checking bench for mem_stage_ws.
// Transaction-level reference model plus directed literal checks.
module tb_mem_stage_ws;

    localparam int TMO = 15;
    localparam logic [15:0] IR_ADD = 16'h0923;
    localparam logic [15:0] IR_LD  = 16'h9045;
    localparam logic [15:0] IR_ST  = 16'h9801;

    logic        clock = 1'b0;
    logic        reset;
    logic        state;
    logic [15:0] mem_ir;
    logic [15:0] reg_C;
    logic [15:0] smdr1;
    logic        dw;
    logic [15:0] d_datain;
    logic        d_ready;
    logic [15:0] wb_ir;
    logic [15:0] reg_C1;
    logic [15:0] d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic        d_re;
    logic        stall;
    logic        mem_err;

    int npass  = 0;
    int ntotal = 0;

    mem_stage_ws #(
        .DW(16), .AW(16), .IRW(16), .OPW(5), .TMO(TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .state     (state),
        .mem_ir    (mem_ir),
        .reg_C     (reg_C),
        .smdr1     (smdr1),
        .dw        (dw),
        .d_datain  (d_datain),
        .d_ready   (d_ready),
        .wb_ir     (wb_ir),
        .reg_C1    (reg_C1),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we),
        .d_re      (d_re),
        .stall     (stall),
        .mem_err   (mem_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: one outstanding access record and its wait age
    bit          m_known = 0;
    bit          busy = 0;
    int          waited = 0;
    logic [15:0] r_addr, r_data, r_ir;
    bit          r_load;
    logic [15:0] m_wb, m_c1;
    bit          m_err;

    always @(negedge clock) begin
        bit ld_now, memop, acc, ld, st, e_re, e_we, e_stall;
        logic [15:0] e_addr, e_data;
        if (m_known) begin
            chk("m_wb_ir", wb_ir, m_wb);
            chk("m_reg_C1", reg_C1, m_c1);
            chk("m_mem_err", mem_err, m_err);
        end
        ld_now  = (mem_ir[15:11] == 5'b10010);
        memop   = ld_now || dw;
        acc     = busy || (state && memop);
        e_addr  = busy ? r_addr : reg_C;
        e_data  = busy ? r_data : smdr1;
        ld      = busy ? r_load : ld_now;
        st      = busy ? !r_load : (dw && !ld_now);
        e_re    = reset && acc && ld;
        e_we    = reset && acc && st;
        e_stall = acc && !d_ready && !(busy && waited == TMO);
        if (m_known) begin
            chk("m_d_re", d_re, e_re);
            chk("m_d_we", d_we, e_we);
            chk("m_stall", stall, e_stall);
            if (acc && reset) begin
                chk("m_d_addr", d_addr, e_addr);
                chk("m_d_dataout", d_dataout, e_data);
            end
        end
        if (!reset) begin
            busy = 0; waited = 0; m_wb = 0; m_c1 = 0; m_err = 0;
            m_known = 1;
        end else if (busy) begin
            if (d_ready) begin
                m_wb = r_ir; m_c1 = r_load ? d_datain : r_addr; busy = 0;
            end else if (waited == TMO) begin
                m_wb = r_ir; m_c1 = 0; m_err = 1; busy = 0;
            end else begin
                waited++; m_wb = 0;
            end
        end else if (state) begin
            if (!memop) begin
                m_wb = mem_ir; m_c1 = reg_C;
            end else if (d_ready) begin
                m_wb = mem_ir; m_c1 = ld_now ? d_datain : reg_C;
            end else begin
                busy = 1; waited = 1; m_wb = 0;
                r_addr = reg_C; r_data = smdr1; r_ir = mem_ir;
                r_load = ld_now;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic drive(input logic st, input logic [15:0] ir,
                         input logic [15:0] c, input logic [15:0] sd,
                         input logic w, input logic rdy,
                         input logic [15:0] din);
        state = st; mem_ir = ir; reg_C = c; smdr1 = sd;
        dw = w; d_ready = rdy; d_datain = din;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0);
        tick(); tick();
        chk("rst_wb_ir", wb_ir, 16'h0);
        chk("rst_reg_C1", reg_C1, 16'h0);
        chk("rst_mem_err", mem_err, 1'b0);
        reset = 1'b1;

        drive(1, IR_ADD, 16'h1234, 16'h0, 0, 0, 16'h0);
        mid(); chk("t1_stall", stall, 1'b0);
        tick();
        chk("t1_wb_ir", wb_ir, 16'h0923);
        chk("t1_reg_C1", reg_C1, 16'h1234);

        drive(1, IR_LD, 16'h0040, 16'h0, 0, 1, 16'hBEEF);
        mid();
        chk("t2_d_re", d_re, 1'b1);
        chk("t2_d_addr", d_addr, 16'h0040);
        chk("t2_stall", stall, 1'b0);
        tick();
        chk("t2_reg_C1", reg_C1, 16'hBEEF);
        chk("t2_wb_ir", wb_ir, 16'h9045);

        drive(1, IR_LD, 16'h0040, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t3_stall", stall, 1'b1);
            chk("t3_d_addr", d_addr, 16'h0040);
            tick();
            chk("t3_wb_ir_bubble", wb_ir, 16'h0);
            drive(1, IR_ADD, 16'hFFFF, 16'h0, 0, 0, 16'h0);
        end
        drive(1, IR_ADD, 16'hFFFF, 16'h0, 0, 1, 16'hCAFE);
        mid();
        chk("t3_stall_done", stall, 1'b0);
        chk("t3_d_addr_done", d_addr, 16'h0040);
        tick();
        chk("t3_reg_C1", reg_C1, 16'hCAFE);
        chk("t3_wb_ir", wb_ir, 16'h9045);
        drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0);
        tick();

        drive(1, IR_ST, 16'h0010, 16'h00AA, 1, 0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("t4_d_we", d_we, 1'b1);
            chk("t4_d_dataout", d_dataout, 16'h00AA);
            chk("t4_stall", stall, 1'b1);
            tick();
            drive(1, IR_ADD, 16'h0000, 16'h0000, 0, 0, 16'h0);
        end
        d_ready = 1'b1;
        mid();
        chk("t4_d_we_done", d_we, 1'b1);
        chk("t4_dataout_done", d_dataout, 16'h00AA);
        chk("t4_stall_done", stall, 1'b0);
        tick();
        chk("t4_reg_C1", reg_C1, 16'h0010);
        chk("t4_wb_ir", wb_ir, 16'h9801);
        drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0);
        tick();

        drive(1, IR_LD, 16'h0050, 16'h0, 0, 0, 16'h0);
        n = 0;
        for (int i = 0; i < TMO + 1; i++) begin
            mid();
            if (stall) n++;
            tick();
        end
        chk("t5_stall_cycles", n, 15);
        chk("t5_mem_err", mem_err, 1'b1);
        chk("t5_reg_C1", reg_C1, 16'h0);
        chk("t5_wb_ir", wb_ir, 16'h9045);
        drive(1, IR_ADD, 16'h5678, 16'h0, 0, 0, 16'h0);
        tick();
        chk("t5_add_wb_ir", wb_ir, 16'h0923);
        chk("t5_add_reg_C1", reg_C1, 16'h5678);
        chk("t5_err_sticky", mem_err, 1'b1);

        drive(1, IR_LD, 16'h0060, 16'h0, 0, 0, 16'h0);
        tick(); tick();
        reset = 1'b0;
        mid();
        chk("t6_d_re", d_re, 1'b0);
        chk("t6_d_we", d_we, 1'b0);
        tick();
        chk("t6_wb_ir", wb_ir, 16'h0);
        chk("t6_reg_C1", reg_C1, 16'h0);
        chk("t6_mem_err", mem_err, 1'b0);
        reset = 1'b1;
        drive(0, 16'h0, 16'h0070, 16'h0, 0, 0, 16'h0);
        mid();
        chk("t6_idle_d_re", d_re, 1'b0);
        chk("t6_idle_stall", stall, 1'b0);
        chk("t6_idle_addr", d_addr, 16'h0070);
        tick();

        drive(1, IR_LD, 16'h0080, 16'h0055, 1, 1, 16'h1357);
        mid();
        chk("t7_d_we", d_we, 1'b0);
        chk("t7_d_re", d_re, 1'b1);
        tick();
        chk("t7_reg_C1", reg_C1, 16'h1357);
        drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0);
        tick(); tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
